// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional per-requester completion counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]      stat0_count,
    output logic [15:0]      stat1_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_owner;
    logic             r_lastGrant;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_respDone;

    // On a tie the requester that did not win last time gets the ALU.
    assign w_grant0 = req0_valid && (!req1_valid || r_lastGrant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_lastGrant);

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_ctrl     = r_op;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_zero   = r_zero;
    assign resp1_zero   = r_zero;

    always_comb begin
        w_nextState = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        w_accept    = 1'b0;
        w_respDone  = 1'b0;
        case (r_state)
            IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_accept    = 1'b1;
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                w_nextState = RESP;
            end
            RESP: begin
                resp0_valid = !r_owner;
                resp1_valid = r_owner;
                if (r_owner ? resp1_ready : resp0_ready) begin
                    w_respDone  = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_a         <= w_grant0 ? req0_a  : req1_a;
                r_b         <= w_grant0 ? req0_b  : req1_b;
                r_op        <= w_grant0 ? req0_op : req1_op;
                r_owner     <= w_grant1;
                r_lastGrant <= w_grant1;
            end
            // Opcodes with the top bit set are undefined for the ALU; report a clean zero.
            if (r_state == EXEC) begin
                r_result <= r_op[2] ? '0 : alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else if (w_respDone) begin
            if (r_owner) r_stat1 <= r_stat1 + 16'd1;
            else         r_stat0 <= r_stat0 + 16'd1;
        end
    end

    assign stat0_count = r_stat0;
    assign stat1_count = r_stat1;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU (AND/OR/ADD/SUB, 3-bit control, equality `zero` flag) between two requesters, e.g. the main datapath and a coprocessor/debug port.
- Round-robin grant with valid/ready request handshake and valid/ready response handshake.
- Operands and operation are latched, the ALU is driven for one cycle, and the result is registered.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 3, ALU control width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 operand A
- req0_b  in  WIDTH  requester 0 operand B
- req0_op  in  OPW  requester 0 ALU control (000 AND, 001 OR, 010 ADD, 011 SUB)
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 consumes result
- resp0_result  out  WIDTH  result to requester 0
- resp0_zero  out  1  equality flag to requester 0 (A==B)
- req1_*, resp1_*  same set for requester 1
- alu_a  out  WIDTH  to ALU dataA
- alu_b  out  WIDTH  to ALU dataB
- alu_ctrl  out  OPW  to ALU aluCtrl
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero

Behaviour:
- Clock/reset: clk only; reset synchronous active-high; all state updates on the rising edge of clk.
- Reset values:
  - FSM=IDLE; last_grant=1, so requester 0 wins the first tie.
  - Operand, op, result, zero and owner registers = 0.
  - reqN_ready=0 and respN_valid=0 (both are decoded from state).
  - alu_a/alu_b/alu_ctrl = 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, grant that requester. If both are high, grant the requester other than last_grant.
  - reqN_ready = grantN, asserted only in IDLE.
  - On handshake: latch a, b, op and owner=N; set last_grant=N; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl driven from the latched registers; they hold those values in all states.
  - Capture alu_result into the result register. If latched op[2]=1 (undefined op), capture 0 instead.
  - Capture alu_zero unconditionally; go to RESP.
- RESP:
  - resp{owner}_valid=1; the other respN_valid=0.
  - Result/zero visible on both respN_result/respN_zero buses; only the valid qualifies them.
  - Stay in RESP until resp{owner}_ready=1, then go to IDLE.
  - No new request is accepted while in EXEC or RESP (reqN_ready=0).
- Latency and throughput:
  - Accept at edge T, resp_valid high from T+2.
  - With resp_ready tied high, one operation per 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Handshake rules:
  - Requesters must hold a, b and op stable while valid and not ready.
  - Dropping valid before ready is permitted; nothing is latched.
- Reset mid-operation (EXEC or RESP): return to IDLE and clear all registers. The pending response is discarded and is never delivered.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no overflow flag; zero is the ALU equality flag, not result==0.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat0_count and stat1_count, each 16 bits.
  - Each counter increments on every completed response handshake for its requester (resp valid && ready).
  - Wraps at 16'hFFFF to 0; cleared by reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then req0 ADD a=32'h7FFFFFFF b=1 -> ready same cycle; resp0_valid 2 cycles later; result=32'h80000000, zero=0.
- req1 SUB a=b=32'h1234 with resp1_ready held low 5 cycles -> resp1_valid held 5 cycles, result=0, zero=1; req0_valid meanwhile gets no ready.
- Both valid continuously, req0 AND / req1 OR, a=32'hF0F0F0F0 b=32'h0FF00FF0, resp_ready=1 -> grants 0,1,0,1; results 32'h00F000F0 / 32'hFFF0FFF0 alternate.
- req0 op=3'b110 a=5 b=5 -> result=0, zero=1, FSM returns to IDLE.
- Reset asserted during EXEC of req0 ADD -> no resp0_valid ever; next req1 is granted first (last_grant reset to 1, sole request).
- ALU_ARB_STATS_EN defined: 3 req0 ops + 2 req1 ops complete -> stat0_count=3, stat1_count=2.
